// File: rtl/timer_bank_if.sv
// Register-access bus and channel outputs of the timer bank.
interface timer_bank_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int CHW   = 2
);
  logic             we;
  logic [CHW-1:0]   ch_sel;
  logic [1:0]       reg_sel;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic [NCH-1:0]   cnt_out;
  logic             irq;

  modport master (output we, ch_sel, reg_sel, wdata, input rdata, cnt_out, irq);
  modport slave  (input we, ch_sel, reg_sel, wdata, output rdata, cnt_out, irq);
endinterface

// File: rtl/timer_bank.sv
// Multi-channel programmable timer: one-shot, periodic and PWM modes with
// per-channel power-of-two prescalers, W1C status and one maskable irq.
module timer_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int CHW   = 2
) (
  input logic         clk,
  input logic         RSTN,
  timer_bank_if.slave bus
);
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_PWM      = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    REG_COUNT  = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_CMP    = 2'd3
  } reg_e;

  typedef struct packed {
    logic [3:0] p;
    logic       ie;
    logic       en;
    mode_e      mode;
  } ctrl_t;

  logic [WIDTH-1:0] count_q [NCH];
  logic [WIDTH-1:0] count_d [NCH];
  logic [WIDTH-1:0] load_q  [NCH];
  logic [WIDTH-1:0] load_d  [NCH];
  logic [WIDTH-1:0] cmp_q   [NCH];
  logic [WIDTH-1:0] cmp_d   [NCH];
  ctrl_t            ctrl_q  [NCH];
  ctrl_t            ctrl_d  [NCH];
  logic [15:0]      pre_q   [NCH];
  logic [15:0]      pre_d   [NCH];

  logic [NCH-1:0]   out_q, out_d, status_q, status_d;
  logic [NCH-1:0]   set_evt, ie_d, clr, tick, wsel;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             reload;
  reg_e             reg_sel;
  logic [IDXW-1:0]  ch_idx;

  assign reg_sel = reg_e'(bus.reg_sel);
  assign ch_idx  = IDXW'(bus.ch_sel);

  // Tick fires on the last prescaler step of a 2^p window.
  always_comb begin
    tick = '0;
    wsel = '0;
    for (int i = 0; i < NCH; i++) begin
      tick[i] = ctrl_q[i].en && (pre_q[i] == ((16'd1 << ctrl_q[i].p) - 16'd1));
      wsel[i] = bus.we && (bus.ch_sel == CHW'(i));
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    set_evt = '0;
    out_d   = out_q;
    clr     = '0;
    ie_d    = '0;
    reload  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      count_d[i] = count_q[i];
      load_d[i]  = load_q[i];
      cmp_d[i]   = cmp_q[i];
      ctrl_d[i]  = ctrl_q[i];
      pre_d[i]   = '0;

      if (ctrl_q[i].en) begin
        pre_d[i] = tick[i] ? 16'd0 : pre_q[i] + 16'd1;
        reload   = tick[i] && (count_q[i] == WIDTH'(1));
        if (tick[i] && count_q[i] > WIDTH'(1)) count_d[i] = count_q[i] - WIDTH'(1);
        case (ctrl_q[i].mode)
          MODE_ONESHOT: begin
            if (reload) begin
              count_d[i]   = '0;
              out_d[i]     = 1'b1;
              set_evt[i]   = 1'b1;
              ctrl_d[i].en = 1'b0;
            end
          end
          MODE_PERIODIC: begin
            if (reload) begin
              count_d[i] = load_q[i];
              set_evt[i] = 1'b1;
            end
            out_d[i] = reload;
          end
          MODE_PWM: begin
            if (reload) begin
              count_d[i] = load_q[i];
              set_evt[i] = 1'b1;
            end
            out_d[i] = (count_d[i] <= cmp_q[i]);
          end
          default: out_d[i] = 1'b0;
        endcase
      end

      // A register write overrides whatever the tick decided this cycle.
      if (wsel[i] && reg_sel == REG_COUNT) begin
        load_d[i]  = bus.wdata;
        count_d[i] = bus.wdata;
        out_d[i]   = 1'b0;
        pre_d[i]   = '0;
        set_evt[i] = 1'b0;
      end
      if (wsel[i] && reg_sel == REG_CTRL) begin
        ctrl_d[i] = ctrl_t'(bus.wdata[7:0]);
        pre_d[i]  = '0;
      end
      if (wsel[i] && reg_sel == REG_CMP) cmp_d[i] = bus.wdata;

      if (bus.we && reg_sel == REG_STATUS && i < WIDTH) clr[i] = bus.wdata[i];
      ie_d[i] = ctrl_d[i].ie;
    end
    status_d = (status_q & ~clr) | set_evt;
    irq_d    = |(status_d & ie_d);
  end

  always_comb begin
    rdata_d = '0;
    if (int'(bus.ch_sel) < NCH) begin
      case (reg_sel)
        REG_COUNT:  rdata_d = count_q[ch_idx];
        REG_CTRL:   rdata_d = WIDTH'(ctrl_q[ch_idx]);
        REG_STATUS: begin
          for (int i = 0; i < NCH; i++) if (i < WIDTH) rdata_d[i] = status_q[i];
        end
        default:    rdata_d = cmp_q[ch_idx];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      // NOTE: the per-channel register arrays are flops, not RAM, so they take the reset.
      for (int i = 0; i < NCH; i++) begin
        count_q[i] <= '0;
        load_q[i]  <= '0;
        cmp_q[i]   <= '0;
        ctrl_q[i]  <= '0;
        pre_q[i]   <= '0;
      end
      out_q    <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        count_q[i] <= count_d[i];
        load_q[i]  <= load_d[i];
        cmp_q[i]   <= cmp_d[i];
        ctrl_q[i]  <= ctrl_d[i];
        pre_q[i]   <= pre_d[i];
      end
      out_q    <= out_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.cnt_out = out_q;
  assign bus.irq     = irq_q;
endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: register vectors plus multi-cycle mode sequences.
module tb_timer_bank;
  localparam int NCH = 4;
  localparam int WIDTH = 32;
  localparam int CHW = 3;
  localparam logic [1:0] R_CNT = 2'd0, R_CTRL = 2'd1, R_STAT = 2'd2, R_CMP = 2'd3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  timer_bank_if #(.NCH(NCH), .WIDTH(WIDTH), .CHW(CHW)) bus ();
  timer_bank #(.NCH(NCH), .WIDTH(WIDTH), .CHW(CHW)) dut (.clk(clk), .RSTN(rstn), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    int          ch;
    logic [1:0]  rs;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [1:0] rs, input logic [31:0] d);
    bus.we = 1'b1; bus.ch_sel = CHW'(ch); bus.reg_sel = rs; bus.wdata = d;
    step();
    bus.we = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [1:0] rs, output logic [31:0] v);
    bus.we = 1'b0; bus.ch_sel = CHW'(ch); bus.reg_sel = rs;
    step();
    v = bus.rdata;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  initial begin
    logic [31:0] v;
    int highs;
    bus.we = 1'b0; bus.ch_sel = '0; bus.reg_sel = '0; bus.wdata = '0;

    vecs[0]  = '{1'b1, 0, R_CNT,  32'h0000_1234};
    vecs[1]  = '{1'b1, 1, R_CMP,  32'h0000_ABCD};
    vecs[2]  = '{1'b1, 2, R_CTRL, 32'h0000_01F2};
    vecs[3]  = '{1'b1, 5, R_CNT,  32'h0000_0055};
    vecs[4]  = '{1'b0, 0, R_CNT,  32'h0000_1234};
    vecs[5]  = '{1'b0, 1, R_CMP,  32'h0000_ABCD};
    vecs[6]  = '{1'b0, 2, R_CTRL, 32'h0000_00F2};
    vecs[7]  = '{1'b0, 5, R_CNT,  32'h0000_0000};
    vecs[8]  = '{1'b0, 1, R_CNT,  32'h0000_0000};
    vecs[9]  = '{1'b0, 0, R_STAT, 32'h0000_0000};
    vecs[10] = '{1'b0, 3, R_CMP,  32'h0000_0000};

    // Power-on reset, then activity, then a 2-clk reset.
    step(); step();
    check("por_rdata", bus.rdata, 0);
    rstn = 1'b1;
    wr(3, R_CNT, 7); wr(3, R_CTRL, 32'h0D); wr(1, R_CMP, 32'h99);
    wr(0, R_CNT, 1); wr(0, R_CTRL, 32'h0C);
    step(); step(); step();
    check("pre_reset_irq", bus.irq, 1);
    rstn = 1'b0;
    step(); step();
    check("reset_irq", bus.irq, 0);
    check("reset_cnt_out", bus.cnt_out, 0);
    check("reset_rdata", bus.rdata, 0);
    rstn = 1'b1;
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 4; r++) begin
        rd(c, 2'(r), v);
        check($sformatf("reset_read_ch%0d_r%0d", c, r), v, 0);
      end

    // Register access vectors (all channels disabled).
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].ch, vecs[i].rs, vecs[i].data);
      else begin
        rd(vecs[i].ch, vecs[i].rs, v);
        check($sformatf("vec%0d", i), v, vecs[i].data);
      end
    end

    // One-shot: fires 5 clks after the CTRL write.
    wr(0, R_CNT, 5); wr(0, R_CTRL, 32'h0C);
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("oneshot_out_k%0d", k), bus.cnt_out[0], (k == 5) ? 1 : 0);
      if (k >= 4) check($sformatf("oneshot_irq_k%0d", k), bus.irq, (k == 5) ? 1 : 0);
    end
    rd(0, R_CTRL, v); check("oneshot_ctrl_en_cleared", v, 32'h08);
    step(); step();
    rd(0, R_CNT, v);  check("oneshot_count_zero", v, 0);
    check("oneshot_out_held", bus.cnt_out[0], 1);
    wr(6, R_STAT, 32'h1);
    check("oneshot_irq_w1c", bus.irq, 0);

    // Periodic with p=2: one-clk pulse every 12 clks.
    wr(1, R_CNT, 3); wr(1, R_CTRL, 32'h25);
    for (int k = 1; k <= 25; k++) begin
      step();
      check($sformatf("periodic_out_k%0d", k), bus.cnt_out[1], (k == 12 || k == 24) ? 1 : 0);
    end
    rd(1, R_STAT, v); check("periodic_status_set", v, 32'h2);
    wr(1, R_STAT, 32'h2);
    rd(1, R_STAT, v); check("periodic_status_cleared", v, 0);
    wr(1, R_CTRL, 0);

    // PWM: high while count is 3, 2, 1 out of a 10-clk period.
    wr(2, R_CNT, 10); wr(2, R_CMP, 3); wr(2, R_CTRL, 32'h06);
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("pwm_out_k%0d", k), bus.cnt_out[2], (k % 10 >= 7) ? 1 : 0);
    end
    wr(2, R_CMP, 0); step();
    highs = 0;
    for (int k = 0; k < 12; k++) begin step(); highs += int'(bus.cnt_out[2]); end
    check("pwm_cmp0_highs", highs, 0);
    wr(2, R_CMP, 10); step();
    highs = 0;
    for (int k = 0; k < 12; k++) begin step(); highs += int'(bus.cnt_out[2]); end
    check("pwm_cmp_load_highs", highs, 12);
    wr(2, R_CTRL, 0);
    wr(0, R_STAT, 32'hF);

    // LOAD write on a tick cycle: written value survives, tick dropped.
    wr(3, R_CNT, 100); wr(3, R_CTRL, 32'h05);
    step(); step();
    wr(3, R_CNT, 50);
    rd(3, R_CNT, v); check("collide_load_tick", v, 50);
    wr(3, R_CTRL, 0);

    // STATUS clear on the reload cycle: set wins.
    wr(3, R_CNT, 4); wr(3, R_CTRL, 32'h0D);
    for (int k = 0; k < 7; k++) step();
    check("collide_irq_before", bus.irq, 1);
    wr(0, R_STAT, 32'h8);
    check("collide_irq_after", bus.irq, 1);
    rd(3, R_STAT, v); check("collide_status", v, 32'h8);

    // Reset while ch3 is mid-period.
    rstn = 1'b0;
    step();
    check("midreset_cnt_out", bus.cnt_out, 0);
    check("midreset_irq", bus.irq, 0);
    rstn = 1'b1;
    rd(3, R_CNT, v);  check("midreset_count", v, 0);
    rd(3, R_CTRL, v); check("midreset_ctrl", v, 0);
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      highs += int'(|bus.cnt_out) + int'(bus.irq);
    end
    check("midreset_quiet", highs, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
